// File: rtl/decode_stage.sv
// decode_stage: instruction-decode pipeline stage of the 64-bit RISC-V core.
//
// Drives the register-file read addresses straight from the fetched
// instruction, picks up the returned operands (bypassing a same-cycle
// writeback), decodes the immediate and control bits, and captures everything
// in the ID/EX pipeline register. A load-use dependency on the instruction
// held in ID/EX inserts a single bubble.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   if_valid, if_instr, if_pc    instruction presented by fetch
//   id_ready                     decode consumes if_instr this cycle
//   readRegister1/2              register-file read indices (combinational)
//   readData1/2                  register-file read data
//   wb_regWrite, wb_rd, wb_data  writeback port currently writing registers
//   flush                        kill the ID/EX entry and the fetched instr
//   ex_ready                     execute accepts the ID/EX register
//   ex_*                         ID/EX pipeline register contents
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [63:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  readRegister1,
    output logic [4:0]  readRegister2,
    input  logic [63:0] readData1,
    input  logic [63:0] readData2,
    input  logic        wb_regWrite,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [63:0] ex_pc,
    output logic [63:0] ex_rs1_data,
    output logic [63:0] ex_rs2_data,
    output logic [63:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic [6:0]  ex_funct7,
    output logic        ex_regWrite,
    output logic        ex_memRead,
    output logic        ex_memWrite,
    output logic        ex_illegal
);

    typedef enum logic [6:0] {
        OPC_LOAD      = 7'b0000011,
        OPC_OP_IMM    = 7'b0010011,
        OPC_AUIPC     = 7'b0010111,
        OPC_OP_IMM_32 = 7'b0011011,
        OPC_STORE     = 7'b0100011,
        OPC_OP        = 7'b0110011,
        OPC_LUI       = 7'b0110111,
        OPC_OP_32     = 7'b0111011,
        OPC_BRANCH    = 7'b1100011,
        OPC_JALR      = 7'b1100111,
        OPC_JAL       = 7'b1101111
    } opcode_t;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [63:0] w_imm;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_writes_rd;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_illegal;
    logic [63:0] w_op1;
    logic [63:0] w_op2;
    logic        w_hazard;
    logic        w_advance;

    assign w_opcode = if_instr[6:0];
    assign w_rd     = if_instr[11:7];
    assign w_rs1    = if_instr[19:15];
    assign w_rs2    = if_instr[24:20];

    assign readRegister1 = w_rs1;
    assign readRegister2 = w_rs2;

    // Immediate format, register usage and control bits by opcode.
    always_comb begin
        w_imm       = '0;
        w_rs1_used  = 1'b1;
        w_rs2_used  = 1'b0;
        w_writes_rd = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        case (w_opcode)
            OPC_LOAD: begin
                w_imm       = {{52{if_instr[31]}}, if_instr[31:20]};
                w_writes_rd = 1'b1;
                w_mem_read  = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
                w_imm       = {{52{if_instr[31]}}, if_instr[31:20]};
                w_writes_rd = 1'b1;
            end
            OPC_STORE: begin
                w_imm       = {{52{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                w_rs2_used  = 1'b1;
                w_mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm      = {{52{if_instr[31]}}, if_instr[7], if_instr[30:25],
                              if_instr[11:8], 1'b0};
                w_rs2_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm       = {{32{if_instr[31]}}, if_instr[31:12], 12'h000};
                w_rs1_used  = 1'b0;
                w_writes_rd = 1'b1;
            end
            OPC_JAL: begin
                w_imm       = {{44{if_instr[31]}}, if_instr[19:12], if_instr[20],
                               if_instr[30:21], 1'b0};
                w_rs1_used  = 1'b0;
                w_writes_rd = 1'b1;
            end
            OPC_OP, OPC_OP_32: begin
                w_rs2_used  = 1'b1;
                w_writes_rd = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Operand select: x0 reads as zero; a write landing this very cycle
    // is not yet visible through the register file, so bypass it.
    always_comb begin
        if (w_rs1 == 5'd0)
            w_op1 = '0;
        else if (wb_regWrite && (wb_rd == w_rs1))
            w_op1 = wb_data;
        else
            w_op1 = readData1;

        if (w_rs2 == 5'd0)
            w_op2 = '0;
        else if (wb_regWrite && (wb_rd == w_rs2))
            w_op2 = wb_data;
        else
            w_op2 = readData2;
    end

    assign w_hazard = ex_valid && ex_memRead && (ex_rd != 5'd0) &&
                      (((ex_rd == w_rs1) && w_rs1_used) ||
                       ((ex_rd == w_rs2) && w_rs2_used));

    assign w_advance = !ex_valid || ex_ready;
    assign id_ready  = flush || (w_advance && !w_hazard);

    // Flush and bubble only clear ex_valid; the payload is left as is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_regWrite <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (w_advance) begin
            if (if_valid && !w_hazard) begin
                ex_valid    <= 1'b1;
                ex_pc       <= if_pc;
                ex_rs1_data <= w_op1;
                ex_rs2_data <= w_op2;
                ex_imm      <= w_imm;
                ex_rd       <= w_rd;
                ex_opcode   <= w_opcode;
                ex_funct3   <= if_instr[14:12];
                ex_funct7   <= if_instr[31:25];
                ex_regWrite <= w_writes_rd && (w_rd != 5'd0);
                ex_memRead  <= w_mem_read;
                ex_memWrite <= w_mem_write;
                ex_illegal  <= w_illegal;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// A behavioural register file and ID/EX model live in the bench; directed
// sequences with literal expectations come first, then random traffic.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic [4:0]  readRegister1, readRegister2;
    logic [63:0] readData1, readData2;
    logic        wb_regWrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_regWrite, ex_memRead, ex_memWrite, ex_illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .id_ready(id_ready),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .readData1(readData1), .readData2(readData2),
        .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .ex_illegal(ex_illegal)
    );

    // Behavioural register file; x0 deliberately holds junk to prove the
    // decoder forces index 0 to zero itself.
    logic [63:0] regs [32];
    assign readData1 = regs[if_instr[19:15]];
    assign readData2 = regs[if_instr[24:20]];

    typedef struct packed {
        logic        v;
        logic [63:0] pc, a, b, imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw, mr, mw, ill;
    } ex_t;

    typedef struct packed {
        logic        rs1u, rs2u, rw, mr, mw, ill;
        logic [63:0] imm;
    } info_t;

    ex_t m;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode by the ISA's rules, immediates built as signed arithmetic sums.
    function automatic info_t decode(input logic [31:0] ins);
        info_t  r;
        longint t;
        logic   writer;
        r = '0;
        r.rs1u = 1'b1;
        writer = 1'b0;
        t = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67: begin
                t = (ins[31] ? -longint'(2048) : 0) + longint'(ins[30:20]);
                writer = 1'b1;
                r.mr = (ins[6:0] == 7'h03);
            end
            7'h23: begin
                t = (ins[31] ? -longint'(2048) : 0) + longint'(ins[30:25]) * 32
                    + longint'(ins[11:7]);
                r.rs2u = 1'b1;
                r.mw = 1'b1;
            end
            7'h63: begin
                t = (ins[31] ? -longint'(4096) : 0) + longint'(ins[7]) * 2048
                    + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                r.rs2u = 1'b1;
            end
            7'h37, 7'h17: begin
                t = (ins[31] ? -(longint'(1) << 31) : 0) + (longint'(ins[30:12]) << 12);
                r.rs1u = 1'b0;
                writer = 1'b1;
            end
            7'h6F: begin
                t = (ins[31] ? -(longint'(1) << 20) : 0) + (longint'(ins[19:12]) << 12)
                    + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                r.rs1u = 1'b0;
                writer = 1'b1;
            end
            7'h33, 7'h3B: begin
                r.rs2u = 1'b1;
                writer = 1'b1;
            end
            default: r.ill = 1'b1;
        endcase
        r.imm = t;
        r.rw = writer && (ins[11:7] != 0);
        return r;
    endfunction

    function automatic logic [63:0] operand(input logic [4:0] idx);
        if (idx == 0) return 64'd0;
        if (wb_regWrite && wb_rd == idx) return wb_data;
        return regs[idx];
    endfunction

    function automatic logic model_hazard();
        info_t d;
        d = decode(if_instr);
        return m.v && m.mr && m.rd != 0 &&
               ((m.rd == if_instr[19:15] && d.rs1u) || (m.rd == if_instr[24:20] && d.rs2u));
    endfunction

    // One clock: check combinational outputs, advance model at the edge,
    // then check the ID/EX register.
    task automatic cycle();
        info_t d;
        logic  hz, adv;
        #1;
        if (reset) m = '0;
        hz  = model_hazard();
        adv = !m.v || ex_ready;
        chk("id_ready", id_ready, flush || (adv && !hz));
        chk("readRegister1", readRegister1, if_instr[19:15]);
        chk("readRegister2", readRegister2, if_instr[24:20]);
        @(posedge clk);
        if (reset) begin
            m = '0;
        end else if (flush) begin
            m.v = 1'b0;
        end else if (adv && if_valid && !hz) begin
            d = decode(if_instr);
            m.v = 1'b1;
            m.pc = if_pc;
            m.a = operand(if_instr[19:15]);
            m.b = operand(if_instr[24:20]);
            m.imm = d.imm;
            m.rd = if_instr[11:7];
            m.op = if_instr[6:0];
            m.f3 = if_instr[14:12];
            m.f7 = if_instr[31:25];
            m.rw = d.rw;
            m.mr = d.mr;
            m.mw = d.mw;
            m.ill = d.ill;
        end else if (adv) begin
            m.v = 1'b0;
        end
        if (wb_regWrite) regs[wb_rd] = wb_data;
        #1;
        chk("ex_valid", ex_valid, m.v);
        if (m.v) begin
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_rs1_data", ex_rs1_data, m.a);
            chk("ex_rs2_data", ex_rs2_data, m.b);
            if (!m.ill) chk("ex_imm", ex_imm, m.imm);
            chk("ex_rd", ex_rd, m.rd);
            chk("ex_opcode", ex_opcode, m.op);
            chk("ex_funct3", ex_funct3, m.f3);
            chk("ex_funct7", ex_funct7, m.f7);
            chk("ex_regWrite", ex_regWrite, m.rw);
            chk("ex_memRead", ex_memRead, m.mr);
            chk("ex_memWrite", ex_memWrite, m.mw);
            chk("ex_illegal", ex_illegal, m.ill);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        if_valid = v;
        if_instr = ins;
        if_pc    = if_pc + 64'd4;
        ex_ready = rdy;
        flush    = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] w;
        ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                7'h33, 7'h3B, 7'h00};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 11)];
        if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        m = '0;
        reset = 1'b1;
        if_valid = 1'b1; if_instr = 32'hFFF00293; if_pc = 64'h8000_0000;
        wb_regWrite = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; ex_ready = 1'b1;

        // Reset: ID/EX cleared, id_ready high.
        cycle();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_id_ready", id_ready, 1);
        reset = 1'b0;

        // addi x5,x0,-1
        drive(1, 32'hFFF00293, 1, 0);
        cycle();
        chk("addi_valid", ex_valid, 1);
        chk("addi_rd", ex_rd, 5);
        chk("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rs1", ex_rs1_data, 0);
        chk("addi_regWrite", ex_regWrite, 1);

        // add x1,x3,x3 with same-cycle writeback to x3
        drive(1, 32'h003180B3, 1, 0);
        wb_regWrite = 1; wb_rd = 3; wb_data = 64'h1234_5678;
        cycle();
        chk("bypass_rs1", ex_rs1_data, 64'h1234_5678);
        chk("bypass_rs2", ex_rs2_data, 64'h1234_5678);
        // wb to x0 must not bypass; x3 now holds the earlier write
        drive(1, 32'h003180B3, 1, 0);
        wb_rd = 0; wb_data = 64'hDEAD;
        cycle();
        chk("nobypass_rs1", ex_rs1_data, 64'h1234_5678);
        wb_regWrite = 0;

        // ld x7,0(x2); add x8,x7,x1 -> one bubble
        drive(1, 32'h00013383, 1, 0);
        cycle();
        drive(1, 32'h00138433, 1, 0);
        #1;
        chk("lu_id_ready_low", id_ready, 0);
        cycle();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_id_ready_high", id_ready, 1);
        cycle();
        chk("lu_accept_valid", ex_valid, 1);
        chk("lu_accept_rd", ex_rd, 8);

        // ld x7 then lui x7 -> no stall
        drive(1, 32'h00013383, 1, 0);
        cycle();
        drive(1, 32'h123453B7, 1, 0);
        #1;
        chk("lui_no_stall", id_ready, 1);
        cycle();
        chk("lui_imm", ex_imm, 64'h0000_0000_1234_5000);

        // Backpressure for 3 cycles, then release
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hFFF00293, 0, 0);
            #1;
            chk("bp_id_ready", id_ready, 0);
            cycle();
            chk("bp_hold_rd", ex_rd, 7);
        end
        drive(1, 32'hFFF00293, 1, 0);
        cycle();
        chk("bp_release_rd", ex_rd, 5);

        // Flush while stalled
        drive(1, 32'h003180B3, 0, 1);
        #1;
        chk("flush_id_ready", id_ready, 1);
        cycle();
        chk("flush_valid", ex_valid, 0);

        // Illegal opcode
        drive(1, 32'h0000007F, 1, 0);
        cycle();
        chk("ill_illegal", ex_illegal, 1);
        chk("ill_ctrl", {ex_regWrite, ex_memRead, ex_memWrite}, 0);

        // sd x5,-27(x2) with rd field 5
        drive(1, 32'hFE5132A3, 1, 0);
        cycle();
        chk("sd_regWrite", ex_regWrite, 0);
        chk("sd_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFE5);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 199) == 0);
            wb_regWrite = $urandom_range(0, 1);
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom};
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode pipeline stage of the 64-bit RISC-V core, sitting between fetch and execute. It drives the read-address ports of `registers` straight from the incoming instruction and captures the returned operands into the ID/EX pipeline register, bypassing same-cycle writeback data. It also generates the immediate and control bits, and detects load-use hazards, inserting a one-cycle bubble when one occurs. Upstream and downstream handshakes are valid/ready.

## Interface
- No parameters; XLEN fixed at 64, 32 architectural registers.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high.
- `if_valid` in 1: fetch presents an instruction.
- `if_instr` in 32: instruction word.
- `if_pc` in 64: PC of `if_instr`.
- `id_ready` out 1: decode consumes `if_instr` this cycle.
- `readRegister1`, `readRegister2` out 5: to `registers`; equal to `if_instr[19:15]` and `if_instr[24:20]` (combinational).
- `readData1`, `readData2` in 64: from `registers`.
- `wb_regWrite` in 1, `wb_rd` in 5, `wb_data` in 64: writeback port currently driving `registers`.
- `flush` in 1: discard the EX-bound and IF-presented instructions (branch redirect).
- `ex_ready` in 1: execute accepts the ID/EX register.
- `ex_valid` out 1; `ex_pc` out 64; `ex_rs1_data`, `ex_rs2_data` out 64; `ex_imm` out 64; `ex_rd` out 5; `ex_opcode` out 7; `ex_funct3` out 3; `ex_funct7` out 7.
- `ex_regWrite`, `ex_memRead`, `ex_memWrite`, `ex_illegal` out 1 each.

## Operation
- Operand select, per source: register index 0 gives 0; otherwise, if `wb_regWrite` && `wb_rd`==index, use `wb_data`; otherwise use `readDataN`.
- Register usage:
  - rs1 is used by all opcodes except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 is used only by OP (0110011), OP-32 (0111011), STORE (0100011) and BRANCH (1100011).
- Hazard = `ex_valid` && `ex_memRead` && `ex_rd`!=0 && (`ex_rd`==rs1 with rs1 used, or `ex_rd`==rs2 with rs2 used).
- advance = !`ex_valid` || `ex_ready`.
- `id_ready` = `flush` || (advance && !hazard).
- ID/EX register update, in priority order:
  1. `flush`: `ex_valid`←0 (regardless of `ex_ready`).
  2. advance && `if_valid` && !hazard: load the decoded instruction; `ex_valid`←1.
  3. advance: `ex_valid`←0 (bubble).
  4. Otherwise: hold all ex_* outputs.
- Immediates, sign-extended to 64 bits:
  - I-type: LOAD, OP-IMM (0010011), OP-IMM-32 (0011011), JALR (1100111).
  - S-type: STORE.
  - B-type: BRANCH; bit 0 = 0.
  - U-type: LUI, AUIPC; bits 11:0 = 0, bits 63:32 = sign of bit 31.
  - J-type: JAL; bit 0 = 0.
  - OP and OP-32: 0.
- Control bits:
  - `ex_memRead` = LOAD.
  - `ex_memWrite` = STORE.
  - `ex_regWrite` = (OP, OP-32, OP-IMM, OP-IMM-32, LOAD, JAL, JALR, LUI, AUIPC) && rd!=0.
  - Any other opcode: `ex_illegal`=1 and all three write/mem bits 0.
- Operands held in ID/EX are not refreshed while held. Later writes by older instructions are the responsibility of EX forwarding.

## Timing
- Reset: all ex_* outputs 0, including `ex_valid`=0. `id_ready` is combinational, so during reset it equals 1. Reset asserted mid-transfer drops the instruction.
- Latency: an instruction accepted at edge N appears on ex_* from edge N onward (one register stage).
- `readRegisterN` follow `if_instr` with zero latency. `registers` reads are combinational, so operands are valid in the same cycle.
- Bypass applies only to the write occurring in the same cycle. Writes at earlier edges are already visible in `registers`.
- A load-use hazard stalls exactly one cycle: a bubble is inserted, then the dependent instruction is accepted with `ex_rd` of the bubble = don't care.
- Simultaneous hazard and !`ex_ready`: hold; no bubble until `ex_ready`.
- Simultaneous `flush` and hazard: flush wins; `id_ready`=1 and the IF instruction is dropped.

## Test plan
- Reset, then `if_valid`=1 with `addi x5,x0,-1` (0xFFF00293) and `ex_ready`=1: after the next edge, `ex_valid`=1, `ex_rd`=5, `ex_imm`=0xFFFF_FFFF_FFFF_FFFF, `ex_rs1_data`=0, `ex_regWrite`=1.
- Same-cycle bypass: `wb_regWrite`=1, `wb_rd`=3, `wb_data`=0x1234_5678 while decoding `add x1,x3,x3` → `ex_rs1_data`=`ex_rs2_data`=0x1234_5678. With `wb_rd`=0, operands come from `readData`.
- Load-use: `ld x7,0(x2)` followed by `add x8,x7,x1`:
  - Cycle after the load: `id_ready`=0, then a bubble (`ex_valid`=0).
  - The add is accepted one cycle later.
  - `ld` followed by `lui x7,...` → no stall.
- Backpressure: `ex_ready`=0 for 3 cycles with `ex_valid`=1 → `id_ready`=0 and ex_* stable. `ex_ready`=1 → the next instruction loads on the following edge.
- `flush`=1 while `ex_ready`=0 and `ex_valid`=1 → `ex_valid`=0 after the edge; `id_ready`=1 and the IF instruction is not delivered.
- Illegal opcode 0x0000007F → `ex_illegal`=1, and `ex_regWrite`, `ex_memRead`, `ex_memWrite` all 0. `sd` (STORE) with rd field 5 → `ex_regWrite`=0 and `ex_imm` equals the S-type value.
